// File: rtl/fetch_pkg.sv
// Shared entry type and constants for the instruction prefetch queue.
package fetch_pkg;

  localparam int FETCH_WIDTH = 48;
  localparam logic [FETCH_WIDTH-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [FETCH_WIDTH-1:0] pc,
                                              input logic [FETCH_WIDTH-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with flush, pointers wrap mod DEPTH.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 wr_data,
  output fetch_entry_t                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign rd_data = mem[rd_ptr];

  // Count is kept separately from the pointers so full and empty are unambiguous.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr] <= wr_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n || flush)
                                 !(push && count == FULL));

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetch queue between a 1-cycle synchronous instruction ROM and the CPU fetch stage.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FETCH_WIDTH,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       CLK,
  input  logic                       Reset,
  output logic                       RomEn,
  output logic [WIDTH-1:0]           RomAddr,
  input  logic [WIDTH-1:0]           RomInstr,
  input  logic                       Redirect,
  input  logic [WIDTH-1:0]           RedirectPC,
  output logic                       ValidF,
  input  logic                       ReadyF,
  output logic [WIDTH-1:0]           InstrF,
  output logic [WIDTH-1:0]           PCF,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic             inflight;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  // Credit counts the outstanding read but not a same-cycle pop, so a push never hits a full queue.
  assign credit  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign RomEn   = Reset && !Redirect && (credit < (CW+1)'(DEPTH));
  assign RomAddr = fetch_pc;

  assign push       = inflight && !Redirect;
  assign head_valid = Reset && (fifo_count != '0);
  assign pop        = head_valid && ReadyF;
  assign wr_entry   = make_entry(req_pc, RomInstr);

  assign ValidF = head_valid;
  assign InstrF = head_valid ? head.instr : NOP_INSTR;
  assign PCF    = head_valid ? head.pc : '0;
  assign Count  = Reset ? fifo_count : '0;

  // Reset beats redirect, and redirect beats issue; a redirect also drops the read in flight.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (Redirect) begin
      fetch_pc <= RedirectPC;
      inflight <= 1'b0;
    end else begin
      inflight <= RomEn;
      if (RomEn) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (Reset),
    .flush   (Redirect),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: queue-based reference model plus directed literal checks.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int W     = 48;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_en;
  logic [W-1:0]  rom_addr;
  logic [W-1:0]  rom_instr;
  logic          redir;
  logic [W-1:0]  redir_pc;
  logic          valid;
  logic          ready;
  logic [W-1:0]  instr;
  logic [W-1:0]  pc;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  fetch_entry_t mq[$];
  logic [W-1:0] m_pc;
  logic [W-1:0] m_req_pc;
  bit           m_inflight;
  bit           e_valid;
  bit           e_romen;
  logic [63:0]  junk;

  always #5 clk = ~clk;

  instr_fetch_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .Reset      (rst),
    .RomEn      (rom_en),
    .RomAddr    (rom_addr),
    .RomInstr   (rom_instr),
    .Redirect   (redir),
    .RedirectPC (redir_pc),
    .ValidF     (valid),
    .ReadyF     (ready),
    .InstrF     (instr),
    .PCF        (pc),
    .Count      (count)
  );

  function automatic logic [W-1:0] rom_word(input logic [W-1:0] a);
    return a + W'(100);
  endfunction

  // Synchronous ROM; garbage when not read so stale data cannot go unnoticed.
  always @(posedge clk) begin
    junk = {$urandom, $urandom};
    if (rom_en) rom_instr <= rom_word(rom_addr);
    else        rom_instr <= junk[W-1:0];
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rd, input logic [W-1:0] rpc, input bit rdy);
    @(negedge clk);
    rst      = r;
    redir    = rd;
    redir_pc = rpc;
    ready    = rdy;
    #1;
  endtask

  task automatic checkOutput();
    int occ;
    occ     = mq.size();
    e_valid = rst && (occ > 0);
    e_romen = rst && !redir && (occ + int'(m_inflight) < DEPTH);
    compare("valid",    W'(valid),  W'(e_valid));
    compare("count",    W'(count),  rst ? W'(occ) : '0);
    compare("rom_en",   W'(rom_en), W'(e_romen));
    compare("rom_addr", rom_addr,   m_pc);
    compare("pc",       pc,         e_valid ? mq[0].pc : '0);
    compare("instr",    instr,      e_valid ? mq[0].instr : '0);
  endtask

  task automatic endCycle();
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_pc       = '0;
      m_inflight = 1'b0;
    end else if (redir) begin
      mq.delete();
      m_pc       = redir_pc;
      m_inflight = 1'b0;
    end else begin
      if (e_valid && ready) void'(mq.pop_front());
      if (m_inflight) mq.push_back(make_entry(m_req_pc, rom_word(m_req_pc)));
      m_inflight = e_romen;
      if (e_romen) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + W'(1);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rd, input logic [W-1:0] rpc, input bit rdy);
    applyStimulus(r, rd, rpc, rdy);
    checkOutput();
  endtask

  task automatic step(input bit r, input bit rd, input logic [W-1:0] rpc, input bit rdy);
    cyc(r, rd, rpc, rdy);
    endCycle();
  endtask

  initial begin
    logic [63:0] rnd;
    logic [W-1:0] rpc;
    bit r, rd, rdy;
    rst = 1'b0; redir = 1'b0; redir_pc = '0; ready = 1'b0; rom_instr = '0;
    mq.delete(); m_pc = '0; m_req_pc = '0; m_inflight = 1'b0;
    repeat (2) @(posedge clk);

    cyc(0, 0, '0, 1);
    compare("lit_reset_valid", W'(valid), '0);
    compare("lit_reset_romen", W'(rom_en), '0);
    compare("lit_reset_addr", rom_addr, '0);
    endCycle();

    // Streaming from reset release with the CPU always ready.
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, '0, 1);
      if (k == 0) begin
        compare("lit_first_romen", W'(rom_en), W'(1));
        compare("lit_first_addr", rom_addr, W'(0));
      end
      if (k == 1) begin
        compare("lit_second_addr", rom_addr, W'(1));
        compare("lit_not_yet_valid", W'(valid), '0);
      end
      if (k >= 2 && k <= 4) begin
        compare("lit_stream_valid", W'(valid), W'(1));
        compare("lit_stream_pc", pc, W'(k - 2));
        compare("lit_stream_instr", instr, W'(k + 98));
      end
      endCycle();
    end

    // Stalled CPU fills the queue, then drains.
    step(0, 0, '0, 0);
    repeat (8) step(1, 0, '0, 0);
    cyc(1, 0, '0, 0);
    compare("lit_full_count", W'(count), W'(4));
    compare("lit_full_romen", W'(rom_en), '0);
    compare("lit_full_addr", rom_addr, W'(4));
    compare("lit_full_head", instr, W'(100));
    endCycle();
    repeat (8) step(1, 0, '0, 1);

    // Redirect with two queued and one outstanding.
    step(0, 0, '0, 0);
    repeat (3) step(1, 0, '0, 0);
    cyc(1, 1, W'(40), 0);
    compare("lit_pre_redir_count", W'(count), W'(2));
    endCycle();
    cyc(1, 0, '0, 1);
    compare("lit_post_redir_valid", W'(valid), '0);
    compare("lit_post_redir_count", W'(count), '0);
    compare("lit_post_redir_addr", rom_addr, W'(40));
    endCycle();
    step(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    compare("lit_redir_pc", pc, W'(40));
    compare("lit_redir_instr", instr, W'(140));
    endCycle();

    // Simultaneous push and pop at two entries.
    step(0, 0, '0, 0);
    repeat (3) step(1, 0, '0, 0);
    step(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    compare("lit_pushpop_count", W'(count), W'(2));
    compare("lit_pushpop_pc", pc, W'(1));
    endCycle();

    // Fetch PC wraps from all-ones to zero.
    step(1, 1, '1, 1);
    cyc(1, 0, '0, 1);
    compare("lit_wrap_max_addr", rom_addr, '1);
    endCycle();
    cyc(1, 0, '0, 1);
    compare("lit_wrap_zero_addr", rom_addr, '0);
    endCycle();
    cyc(1, 0, '0, 1);
    compare("lit_wrap_pc", pc, '1);
    compare("lit_wrap_instr", instr, W'(99));
    endCycle();

    // Reset asserted mid-stream with entries queued and a read outstanding.
    repeat (3) step(1, 0, '0, 0);
    cyc(0, 0, '0, 1);
    compare("lit_midreset_valid", W'(valid), '0);
    compare("lit_midreset_count", W'(count), '0);
    compare("lit_midreset_instr", instr, '0);
    endCycle();
    cyc(1, 0, '0, 1);
    compare("lit_restart_addr", rom_addr, '0);
    compare("lit_restart_count", W'(count), '0);
    endCycle();
    step(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    compare("lit_restart_instr", instr, W'(100));
    endCycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom};
      r   = ($urandom_range(0, 99) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 7 : 2));
      if ($urandom_range(0, 3) == 0) rpc = '1 - W'($urandom_range(0, 7));
      else                           rpc = rnd[W-1:0];
      step(r, rd, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
